// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   WIDTH_DEFAULT : default operand/sum width in bits (legal 2..32)
//   state_e       : controller state encoding (IDLE / RUN / DONE)
package serial_add_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_structural.sv
// One-bit full adder built from discrete gate-level terms. It is the single
// arithmetic cell that the serial controller time-shares across all bits.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : majority(a, b, cin)
module fa_structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_xor;
  logic ab_and;
  logic c_and;

  assign ab_xor = a ^ b;
  assign ab_and = a & b;
  assign c_and  = ab_xor & cin;
  assign sum    = ab_xor ^ cin;
  assign cout   = ab_and | c_and;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Adds two WIDTH-bit operands LSB first, one bit
// per clock, through a single shared full-adder cell.
//
// Handshakes (both sides): a transfer happens on the rising edge where
// valid && ready are both high. A producer holds valid (and its data) until
// that edge; ready may depend on state only, never on valid.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_valid   : request with operands is present
//   start_ready   : controller idle and able to accept a request
//   a_in, b_in    : operands (captured on accept)
//   cin_in        : carry into bit 0 (captured on accept)
//   sum_out       : registered sum, modulo 2^WIDTH
//   cout_out      : registered carry out of the MSB
//   done_valid    : sum_out/cout_out hold a finished result
//   done_ready    : consumer takes the result
//   busy          : an operation is in RUN or DONE
//   dbg_state     : current controller state, for observation only
//
// Timing: the accept edge is edge 0; bit i is processed on edge i+1, so
// done_valid is high after edge WIDTH.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             done_valid_q;
  logic             busy_q;
  logic             start_ready_q;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] a_sh_d;
  logic [WIDTH-1:0] b_sh_d;

  // The shared datapath: always looks at the current LSBs and running carry.
  fa_structural u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sum bits enter at the MSB and walk right, so after WIDTH steps the bit
  // produced first (bit 0) has arrived at position 0.
  assign sum_d  = {fa_sum, sum_q[WIDTH-1:1]};
  assign a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
  assign b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      carry_q       <= 1'b0;
      cnt_q         <= '0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      done_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // start_ready is high throughout IDLE, so start_valid alone
          // completes the handshake here.
          if (start_valid) begin
            a_sh_q        <= a_in;
            b_sh_q        <= b_in;
            carry_q       <= cin_in;
            cnt_q         <= '0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ST_RUN;
          end
        end

        ST_RUN: begin
          sum_q   <= sum_d;
          carry_q <= fa_cout;
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_d;
          cnt_q   <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            cout_q       <= fa_cout;
            done_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Result registers are untouched here, so they stay stable while
          // the consumer stalls.
          if (done_ready) begin
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean idle.
          done_valid_q  <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign sum_out     = sum_q;
  assign cout_out    = cout_q;
  assign done_valid  = done_valid_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         done_valid;
  logic         done_ready;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected {cout, sum} per accepted request, oldest first.
  logic [W:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin_in      (cin_in),
    .sum_out     (sum_out),
    .cout_out    (cout_out),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer addition of the operands and carry-in.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // ---------------- monitor ----------------
  // Inputs change just after rising edges, so the falling edge sees the
  // values that the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n && done_valid && done_ready) begin
      if (exp_q.size() == 0) begin
        chk("result_unexpected", {cout_out, sum_out}, '0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("result", {55'd0, cout_out, sum_out}, {55'd0, e});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_start_ready(output bit ok);
    int n = 0;
    while (!start_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = start_ready;
    if (!ok) chk("start_ready_timeout", {63'd0, start_ready}, 64'd1);
  endtask

  // Full transaction: request, wait for result, stall the consumer for
  // 'hold' cycles, then take the result. 'poke' raises start_valid with
  // junk operands while the controller is busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int hold, input bit poke);
    bit ok;
    int lat;
    bit busy_ok;
    logic [W:0] e;
    e = ref_add(a, b, c);
    wait_start_ready(ok);
    if (!ok) return;
    start_valid = 1'b1;
    a_in = a; b_in = b; cin_in = c;
    exp_q.push_back(e);
    @(posedge clk); #1;               // accept edge (edge 0)
    start_valid = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom_range(0, 1));
    lat = 0;
    busy_ok = 1'b1;
    while (!done_valid && lat < 50) begin
      if (!busy) busy_ok = 1'b0;
      if (poke) begin
        start_valid = 1'b1;
        a_in = W'($urandom);
        chk("start_ready_in_run", {63'd0, start_ready}, 64'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_during_run", {63'd0, busy_ok}, 64'd1);
    chk("latency", 64'(lat), 64'(W));
    for (int i = 0; i < hold; i++) begin
      chk("hold_sum", {55'd0, cout_out, sum_out}, {55'd0, e});
      chk("hold_valid", {63'd0, done_valid}, 64'd1);
      if (poke) begin
        start_valid = 1'b1;
        b_in = W'($urandom);
        chk("start_ready_in_done", {63'd0, start_ready}, 64'd0);
      end
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    @(posedge clk); #1;               // result handshake edge
    done_ready = 1'b0;
    chk("done_valid_cleared", {63'd0, done_valid}, 64'd0);
    chk("start_ready_back", {63'd0, start_ready}, 64'd1);
    chk("busy_cleared", {63'd0, busy}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0;
    done_ready = 1'b0;
    #12;
    chk("reset_outputs", {54'd0, sum_out, cout_out, done_valid, busy}, 64'd0);
    chk("reset_start_ready", {63'd0, start_ready}, 64'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
    do_op(8'h3C, 8'h42, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
    do_op(8'h12, 8'h34, 1'b0, 3, 1'b1);

    // Abort a run partway through with reset.
    wait_start_ready(ok);
    start_valid = 1'b1;
    a_in = 8'hF0; b_in = 8'h0F; cin_in = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {54'd0, sum_out, cout_out, done_valid, busy}, 64'd0);
    chk("abort_start_ready", {63'd0, start_ready}, 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

    // Randomised traffic with consumer backpressure and idle gaps.
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that time-shares one full-adder cell to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
- Captures operands on a valid/ready start handshake, runs WIDTH adder steps, then holds sum and carry-out behind a valid/ready result handshake.
- Sits between a register-file or bus front end and the single full-adder datapath, trading latency for area.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  request carries valid operands.
- start_ready  output  1  controller can accept a request.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- cin_in  input  1  carry-in for bit 0.
- sum_out  output  WIDTH  registered sum.
- cout_out  output  1  registered carry-out of the MSB.
- done_valid  output  1  sum_out/cout_out are valid.
- done_ready  input  1  consumer accepts the result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; sum_out=0, cout_out=0, done_valid=0, busy=0, start_ready=1; internal shift regs, carry and counter cleared.
- States:
  - IDLE: start_ready=1.
  - RUN: start_ready=0, busy=1.
  - DONE: start_ready=0, busy=1, done_valid=1.
- IDLE -> RUN on the edge where start_valid && start_ready:
  - load a_sh=a_in, b_sh=b_in, carry=cin_in, cnt=0.
  - clear sum_out and cout_out.
- RUN, each edge:
  - FA inputs are a_sh[0], b_sh[0], carry.
  - Shift the FA sum into sum_out from the MSB (right shift); carry <= FA cout.
  - a_sh, b_sh shift right; cnt++.
- On the edge where cnt==WIDTH-1 the last bit is processed, cout_out <= FA cout, and the state goes to DONE.
- Latency: the accept edge is edge 0; done_valid is high after edge WIDTH (8 for the default).
- DONE: sum_out, cout_out and done_valid are held stable while done_ready=0. DONE -> IDLE on the edge with done_ready=1; done_valid is low after that edge.
- start_valid outside IDLE is ignored. Operands are not captured, and a_in/b_in/cin_in changes after accept do not affect the result.
- Back-to-back: a new request can be accepted no earlier than the cycle after the result handshake (throughput of 1 op per WIDTH+2 cycles minimum).
- Arithmetic is modulo 2^WIDTH; the carry out of the MSB appears only on cout_out. No overflow flag.
- Counter never wraps in normal operation; it is reset to 0 on every accept.
- Reset asserted mid-RUN or in DONE aborts the operation immediately and returns all outputs to their reset values. The partial result is discarded.
- Unreachable state encoding returns to IDLE.

Decomposition:
- serial_add_pkg include file holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - the WIDTH default.
- One sub-module: the existing fa_structural cell (ports a, b, cin, sum, cout), instantiated once as the shared datapath.
- Everything else (FSM, shift registers, counter) is flat in serial_add_ctrl.

Test Plan:
- A=8'h00, B=8'h00, cin=0 -> sum_out=8'h00, cout_out=0; done_valid rises exactly 8 cycles after the accept edge; busy high throughout.
- A=8'h3C, B=8'h42, cin=0 -> sum_out=8'h7E, cout_out=0.
- A=8'hFF, B=8'h01, cin=0 -> sum_out=8'h00, cout_out=1. Then A=8'hA5, B=8'h5A, cin=1 -> sum_out=8'h00, cout_out=1.
- Hold done_ready=0 for 3 cycles after done_valid with A=8'h12, B=8'h34 -> sum_out=8'h46 stable, done_valid stays 1. start_valid pulsed during RUN and DONE is ignored (start_ready=0, no operand change). Raising done_ready gives IDLE next cycle.
- Assert rst_n=0 after 4 RUN cycles of 8'hF0+8'h0F -> all outputs zero, start_ready=1 asynchronously. After release, 8'h01+8'h01 gives 8'h02.
- Randomised 200 ops with random backpressure, compared against a+b+cin, both sum and carry.
